// File: rtl/arrhythmia_feature_loader.sv
// Feature loader for the arrhythmia decision tree: walks a per-record byte stream,
// keeps the five tree features in a shadow buffer and hands them off as one registered vector.
module arrhythmia_feature_loader #(
    parameter int NUM_FEATURES = 279,
    parameter int IDX_W        = 9,
    parameter int IDX_A        = 13,
    parameter int IDX_B        = 27,
    parameter int IDX_C        = 235,
    parameter int IDX_D        = 264,
    parameter int IDX_E        = 278
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  X13,
    output logic [7:0]  X27,
    output logic [7:0]  X235,
    output logic [7:0]  X264,
    output logic [7:0]  X278,
    output logic        err_len,
    output logic [15:0] rec_count
);

    localparam int NCAP = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);
    localparam logic [NCAP*IDX_W-1:0] CAP_IDX = {IDX_W'(IDX_E), IDX_W'(IDX_D), IDX_W'(IDX_C),
                                                  IDX_W'(IDX_B), IDX_W'(IDX_A)};

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             out_valid_reg, out_valid_next;
    logic             err_len_reg;
    logic [15:0]      rec_count_reg;
    logic             at_last, accept, good_end, bad_end;

    assign at_last = (idx_reg == LAST_IDX);
    // Only the final beat of a record needs a free output register; earlier beats keep streaming.
    assign in_ready = !((state_reg == COLLECT) && at_last && out_valid_reg && !out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        good_end   = 1'b0;
        bad_end    = 1'b0;
        if (accept) begin
            if (state_reg == COLLECT) begin
                if (at_last) begin
                    if (in_last) begin
                        good_end = 1'b1;
                        idx_next = '0;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (in_last) begin
                    bad_end  = 1'b1;
                    idx_next = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end else if (in_last) begin
                bad_end    = 1'b1;
                idx_next   = '0;
                state_next = COLLECT;
            end
        end
    end

    assign out_valid_next = good_end ? 1'b1 : (out_valid_reg && !out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= COLLECT;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            err_len_reg   <= 1'b0;
            rec_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            out_valid_reg <= out_valid_next;
            err_len_reg   <= bad_end;
            if (good_end) begin
                rec_count_reg <= rec_count_reg + 16'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCAP; gi++) begin : g_cap
            logic       hit;
            logic [7:0] shadow_reg;
            logic [7:0] out_reg;

            assign hit = (idx_reg == CAP_IDX[gi*IDX_W +: IDX_W]);

            // A captured index that coincides with the final beat is taken straight from in_data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg <= '0;
                    out_reg    <= '0;
                end else begin
                    if (accept && (state_reg == COLLECT) && hit) begin
                        shadow_reg <= in_data;
                    end
                    if (good_end) begin
                        out_reg <= hit ? in_data : shadow_reg;
                    end
                end
            end
        end
    endgenerate

    assign X13       = g_cap[0].out_reg;
    assign X27       = g_cap[1].out_reg;
    assign X235      = g_cap[2].out_reg;
    assign X264      = g_cap[3].out_reg;
    assign X278      = g_cap[4].out_reg;
    assign out_valid = out_valid_reg;
    assign err_len   = err_len_reg;
    assign rec_count = rec_count_reg;

endmodule

// File: tb/tb_arrhythmia_feature_loader.sv
// Scoreboard bench for arrhythmia_feature_loader: expected vectors are queued as records are
// sent and compared whenever the output handshake completes.
module tb_arrhythmia_feature_loader;

    localparam int NF        = 279;
    localparam int STALL_MAX = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  X13, X27, X235, X264, X278;
    logic        err_len;
    logic [15:0] rec_count;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    logic [39:0] sb[$];
    logic [39:0] held_vec;
    logic        hold_pending = 1'b0;

    always #5 clk = ~clk;

    arrhythmia_feature_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .X13      (X13),
        .X27      (X27),
        .X235     (X235),
        .X264     (X264),
        .X278     (X278),
        .err_len  (err_len),
        .rec_count(rec_count)
    );

    wire [39:0] xvec = {X13, X27, X235, X264, X278};

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] beat_data(input int seed, input int i);
        return 8'((i + seed) & 255);
    endfunction

    function automatic logic [39:0] exp_vec(input int seed);
        return {beat_data(seed, 13), beat_data(seed, 27), beat_data(seed, 235),
                beat_data(seed, 264), beat_data(seed, 278)};
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic last);
        int waitc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waitc < STALL_MAX) begin
            waitc++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("stall_timeout", 40'(in_ready), 40'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // nbeats beats; in_last on the final one if has_last; a well-formed record queues its vector.
    task automatic send_record(input int nbeats, input int seed, input bit has_last, input bit gaps);
        if (nbeats == NF && has_last) begin
            sb.push_back(exp_vec(seed));
        end
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                while ($urandom_range(1) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(beat_data(seed, i), has_last && (i == nbeats - 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'd0;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 1'b0;
            end else begin
                if (out_valid && hold_pending) begin
                    check("hold_stable", xvec, held_vec);
                end
                hold_pending = out_valid && !out_ready;
                held_vec     = xvec;
                if (err_len) begin
                    err_seen++;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_vector", 40'd1, 40'd0);
                    end else begin
                        e = sb.pop_front();
                        check("vector", xvec, e);
                    end
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        do_reset();
        check("rst_out_valid", 40'(out_valid), 40'd0);
        check("rst_vec", xvec, 40'd0);
        check("rst_rec_count", 40'(rec_count), 40'd0);
        check("rst_err_len", 40'(err_len), 40'd0);
        check("rst_in_ready", 40'(in_ready), 40'd1);

        // Single record, data = index; X264=8 and X278=22 after byte wrap
        send_record(NF, 0, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_out_valid", 40'(out_valid), 40'd1);
        check("t1_x264_x278", {24'd0, X264, X278}, {24'd0, 8'd8, 8'd22});
        idle(3);
        check("t1_rec_count", 40'(rec_count), 40'd1);
        check("t1_out_valid_drop", 40'(out_valid), 40'd0);

        // Short record (last at idx 100), then a good one
        send_record(101, 5, 1'b1, 1'b0);
        idle(3);
        check("t2_err", 40'(err_seen), 40'd1);
        check("t2_rec_count", 40'(rec_count), 40'd1);
        send_record(NF, 7, 1'b1, 1'b0);
        idle(3);
        check("t2_rec_count_good", 40'(rec_count), 40'd2);

        // Long record: 285 beats
        send_record(285, 9, 1'b1, 1'b0);
        idle(3);
        check("t3_err", 40'(err_seen), 40'd2);
        check("t3_rec_count", 40'(rec_count), 40'd2);
        check("t3_out_valid", 40'(out_valid), 40'd0);

        // Back-to-back with the second final beat stalled by backpressure
        out_ready = 1'b0;
        send_record(NF, 1, 1'b1, 1'b0);
        fork
            send_record(NF, 2, 1'b1, 1'b0);
            begin
                int n = 0;
                while (in_ready && n < STALL_MAX) begin
                    @(negedge clk);
                    n++;
                end
                check("t4_stall_seen", 40'(in_ready), 40'd0);
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    check("t4_in_ready_low", 40'(in_ready), 40'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("t4_release_ready", 40'(in_ready), 40'd1);
                @(negedge clk);
                check("t4_no_bubble", 40'(out_valid), 40'd1);
            end
        join
        idle(3);
        check("t4_rec_count", 40'(rec_count), 40'd4);
        check("t4_err", 40'(err_seen), 40'd2);

        // Reset mid-record at idx 150, then a full record
        send_record(150, 3, 1'b0, 1'b0);
        do_reset();
        send_record(NF, 11, 1'b1, 1'b0);
        idle(3);
        check("t5_err", 40'(err_seen), 40'd2);
        check("t5_rec_count", 40'(rec_count), 40'd1);

        // Random in_valid gaps
        send_record(NF, 0, 1'b1, 1'b1);
        idle(3);
        check("t6_rec_count", 40'(rec_count), 40'd2);
        check("t6_vec", xvec, exp_vec(0));
        check("sb_drained", 40'(sb.size()), 40'd0);
        check("final_err", 40'(err_seen), 40'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arrhythmia_feature_loader.md
Name: arrhythmia_feature_loader

Overview:
- Upstream stage of the arrhythmia decision-tree classifier.
- Accepts a per-record byte stream of all NUM_FEATURES quantised features, one feature per beat, in index order.
- Captures the five features the tree consumes (X13, X27, X235, X264, X278) into a shadow buffer, then transfers them to a registered output vector with a valid/ready handshake.
- Checks record length and counts good records.

Parameters:
- NUM_FEATURES, 279, beats per well-formed record (feature indices 0..NUM_FEATURES-1)
- IDX_W, 9, width of the beat index counter; must satisfy 2^IDX_W > NUM_FEATURES
- IDX_A, 13, stream index captured to X13
- IDX_B, 27, stream index captured to X27
- IDX_C, 235, stream index captured to X235
- IDX_D, 264, stream index captured to X264
- IDX_E, 278, stream index captured to X278; must be <= NUM_FEATURES-1

Ports:
- clk  input  1  clock, all logic rising-edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  stream beat valid
- in_ready  output  1  stream beat accept; a beat transfers when in_valid && in_ready
- in_data  input  8  feature value for the current index
- in_last  input  1  marks final beat of a record
- out_valid  output  1  feature vector valid to classifier
- out_ready  input  1  classifier accepts the vector
- X13  output  8  captured feature IDX_A
- X27  output  8  captured feature IDX_B
- X235  output  8  captured feature IDX_C
- X264  output  8  captured feature IDX_D
- X278  output  8  captured feature IDX_E
- err_len  output  1  one-cycle pulse: malformed record discarded
- rec_count  output  16  count of records delivered to the output register, wraps at 2^16

Behaviour:
- Reset, synchronous: idx=0, state=COLLECT, shadow=0, X*=0, out_valid=0, err_len=0, rec_count=0. in_ready=1 in the cycle after reset deasserts.
- Reset mid-record: the partial record is dropped silently; no err_len pulse.
- States:
  - COLLECT: each accepted beat with idx==IDX_x writes in_data into shadow_x; idx increments.
  - DRAIN: accept and discard beats until in_last; idx is held.
- Good end: an accepted beat with in_last=1 and idx==NUM_FEATURES-1.
  - Output register loads from shadow, bypassing in_data for any IDX_x equal to the current idx (the default IDX_E=278 is the last beat).
  - out_valid=1 next cycle; rec_count+1; idx=0; remain in COLLECT.
- Short record: in_last=1 with idx<NUM_FEATURES-1.
  - err_len=1 next cycle; idx=0; shadow not cleared; output register untouched.
- Long record: accepted beat at idx==NUM_FEATURES-1 with in_last=0.
  - Go to DRAIN.
  - The beat carrying in_last in DRAIN gives err_len=1 next cycle, idx=0, return to COLLECT.
  - No output transfer.
- Output handshake:
  - out_valid holds until out_valid && out_ready; X* stable while out_valid=1.
  - Vector leaves on the out_ready cycle; out_valid drops next cycle unless a new good end coincides.
- Backpressure: in_ready=0 only when state==COLLECT, idx==NUM_FEATURES-1, out_valid=1 and out_ready=0.
  - The final beat stalls until the output register frees or is being freed that cycle.
  - Otherwise in_ready=1; beats 0..NUM_FEATURES-2 of the next record stream while the previous vector waits.
- Simultaneous consume and good end: in the same cycle, the output register reloads and out_valid stays 1 with no bubble.
- err_len and good end are mutually exclusive per beat.
- Latency: good-end beat to out_valid = 1 cycle. Throughput: one record per NUM_FEATURES cycles at full rate.
- Gaps: in_valid gaps at any point are allowed; idx holds.

Test Plan:
- Stream one record with in_data = idx[7:0], out_ready=1 -> out_valid pulses 1 cycle after beat 278; X13=13, X27=27, X235=235, X264=8, X278=22; rec_count=1.
- Record with in_last at idx 100 -> err_len pulses once; out_valid stays 0; the next well-formed record is delivered correctly.
- Record of 285 beats, in_last on beat 284 -> DRAIN entered at idx 278; err_len pulses after beat 284; no output; rec_count unchanged.
- Two back-to-back records, out_ready=0 until 20 cycles after the second record's beat 277 -> in_ready=0 on the final beat for those cycles; first vector held stable; after out_ready=1 the second vector loads with no bubble.
- rst asserted at idx 150, then a full record -> no err_len; output reflects only the post-reset record; rec_count=1.
- Random in_valid gaps (50% duty) on a full record -> same X* values as the gapless case.
